// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared types and constants for the display scan controller
// Rev 1.0
// ============================================================================
`default_nettype none

package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic bit params_legal(input int num_digits, input int blank_cyc);
        return (num_digits >= 2) && (num_digits <= 8) && (blank_cyc >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_timer.sv
// ============================================================================
// scan_timer : loadable down-counter shared by the blank and drive phases
// Rev 1.0
// ============================================================================
`default_nettype none

module scan_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tc = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ============================================================================
// display_scan_ctrl : multiplexed 7-segment scan with dead-time and LZ blanking
// Rev 1.0
// ============================================================================
`default_nettype none

module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int PRESCALE_W      = 16,
    parameter int BLANK_CYC       = 2,
    parameter int SEL_ACTIVE_HIGH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic                    lz_en,
    input  logic                    inv,
    output logic [3:0]              bcd_code,
    output logic                    dec_en,
    output logic                    dec_inv,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BLK_W = $clog2(BLANK_CYC + 1);
    localparam int CNT_W = (PRESCALE_W > BLK_W) ? PRESCALE_W : BLK_W;
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      BLANK_LOAD = CNT_W'(BLANK_CYC - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF    = {NUM_DIGITS{SEL_ACTIVE_HIGH == 0}};

    generate
        if (!params_legal(NUM_DIGITS, BLANK_CYC)) begin : g_param_check
            $error("display_scan_ctrl: NUM_DIGITS must be 2..8 and BLANK_CYC >= 1");
        end
    endgenerate

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_snap;

    logic                    w_tc;
    logic                    w_go_drive;
    logic                    w_go_blank;
    logic                    w_frame;
    logic [CNT_W-1:0]        w_load_val;
    logic [IDX_W-1:0]        w_next_idx;
    logic [4*NUM_DIGITS-1:0] w_src;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_sup;
    logic                    w_any;
    logic [3:0]              w_code;
    logic                    w_dec_en;
    logic [NUM_DIGITS-1:0]   w_sel;

    assign w_go_drive = ena && (r_state == BLANK) && w_tc;
    assign w_go_blank = ena && ((r_state == IDLE) || ((r_state == DRIVE) && w_tc));
    assign w_load_val = w_go_drive ? CNT_W'(prescale) : BLANK_LOAD;
    assign w_next_idx = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    assign w_frame    = w_go_drive && (w_next_idx == '0);

    // The frame's first slot must already show the value being captured.
    assign w_src = w_frame ? value : r_snap;

    always_comb begin
        w_sup = '0;
        w_any = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_nib[i] = w_src[4*i +: 4];
        end
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_any    = w_any | (w_nib[i] != 4'd0);
            w_sup[i] = lz_en & ~w_any;
        end
    end

    assign w_code   = w_nib[w_next_idx];
    assign w_dec_en = (w_code <= BCD_MAX) && !w_sup[w_next_idx];
    assign w_sel    = (NUM_DIGITS'(1) << w_next_idx) ^ SEL_OFF;

    scan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_go_drive | w_go_blank),
        .load_val (w_load_val),
        .dec      (ena),
        .tc       (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= LAST_IDX;
            r_snap     <= '0;
            bcd_code   <= 4'd0;
            dec_en     <= 1'b0;
            dec_inv    <= 1'b0;
            digit_sel  <= SEL_OFF;
            frame_tick <= 1'b0;
        end else begin
            dec_inv    <= inv;
            frame_tick <= 1'b0;
            if (!ena) begin
                r_state   <= IDLE;
                r_idx     <= LAST_IDX;
                dec_en    <= 1'b0;
                digit_sel <= SEL_OFF;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= BLANK;
                    end
                    BLANK: begin
                        if (w_tc) begin
                            r_state    <= DRIVE;
                            r_idx      <= w_next_idx;
                            bcd_code   <= w_code;
                            dec_en     <= w_dec_en;
                            digit_sel  <= w_sel;
                            frame_tick <= w_frame;
                            if (w_frame) begin
                                r_snap <= value;
                            end
                        end
                    end
                    DRIVE: begin
                        if (w_tc) begin
                            r_state   <= BLANK;
                            dec_en    <= 1'b0;
                            digit_sel <= SEL_OFF;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
// tb_display_scan_ctrl : randomized scoreboard bench for display_scan_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int B  = 2;
    localparam int PW = 16;

    typedef struct packed {
        logic [N-1:0] sel;
        logic [3:0]   code;
        logic         en;
        logic         tick;
        int           len;
        bit           gap_chk;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [4*N-1:0] value;
    logic [PW-1:0] prescale;
    logic          lz_en;
    logic          inv;

    logic [3:0]    bcd_code, bcd_code_n;
    logic          dec_en, dec_en_n;
    logic          dec_inv, dec_inv_n;
    logic [N-1:0]  digit_sel, digit_sel_n;
    logic          frame_tick, frame_tick_n;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    bit   first_pending = 1'b0;

    logic inv_prev = 1'b0;
    logic inv_ok   = 1'b0;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS (N), .PRESCALE_W (PW), .BLANK_CYC (B), .SEL_ACTIVE_HIGH (1)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .ena (ena), .value (value), .prescale (prescale),
        .lz_en (lz_en), .inv (inv), .bcd_code (bcd_code), .dec_en (dec_en),
        .dec_inv (dec_inv), .digit_sel (digit_sel), .frame_tick (frame_tick)
    );

    display_scan_ctrl #(
        .NUM_DIGITS (N), .PRESCALE_W (PW), .BLANK_CYC (B), .SEL_ACTIVE_HIGH (0)
    ) u_dut_n (
        .clk (clk), .rst_n (rst_n), .ena (ena), .value (value), .prescale (prescale),
        .lz_en (lz_en), .inv (inv), .bcd_code (bcd_code_n), .dec_en (dec_en_n),
        .dec_inv (dec_inv_n), .digit_sel (digit_sel_n), .frame_tick (frame_tick_n)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: a digit is dark if its nibble is not BCD, or if leading-zero
    // suppression is on and the number formed by this digit and above is zero.
    task automatic push_frame(input logic [4*N-1:0] v, input bit lz, input int p,
                              input int ndig, input int len_force);
        exp_t e;
        int   nib;
        for (int d = 0; d < ndig; d++) begin
            nib       = int'((v >> (4 * d)) & 16'hF);
            e.sel     = N'(1 << d);
            e.code    = 4'(nib);
            e.en      = (nib <= 9) && !(lz && (d > 0) && ((v >> (4 * d)) == 0));
            e.tick    = (d == 0);
            e.len     = (len_force > 0) ? len_force : p + 1;
            e.gap_chk = !(first_pending && (d == 0));
            first_pending = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic enable();
        ena = 1'b1;
        first_pending = 1'b1;
        step(1);
        step(B - 1);
    endtask

    // Entry: one cycle before a frame-start edge; exit: same position for the next frame.
    task automatic run_frame(input logic [4*N-1:0] v, input bit lz, input int p,
                             input int k, input logic [4*N-1:0] g);
        int f;
        f        = N * (p + 1 + B);
        value    = v;
        lz_en    = lz;
        prescale = PW'(p);
        push_frame(v, lz, p, N, 0);
        step(1);
        step(k);
        value = g;
        step(f - 1 - k);
    endtask

    initial begin
        inv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            inv = 1'($urandom_range(0, 1));
        end
    end

    always @(posedge clk) begin
        inv_prev <= inv;
        inv_ok   <= rst_n;
    end

    // Monitor: a slot is any run of cycles with a digit selected.
    initial begin : monitor
        exp_t         cur;
        bit           in_slot = 1'b0;
        int           slot_len = 0;
        int           gap_cnt = 0;
        logic [N-1:0] exp_n;
        cur = '0;
        forever begin
            @(negedge clk);
            if (digit_sel != '0) begin
                if (!in_slot) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_slot: got sel %0h expected no slot", digit_sel);
                        cur = '0;
                    end else begin
                        cur = q.pop_front();
                    end
                    in_slot  = 1'b1;
                    slot_len = 0;
                    if (cur.gap_chk) chk("blank_gap", gap_cnt, B);
                    chk("frame_tick_first", frame_tick, cur.tick);
                    chk("frame_tick_n_first", frame_tick_n, cur.tick);
                end else begin
                    chk("frame_tick_hold", frame_tick, 0);
                end
                slot_len++;
                exp_n = ~cur.sel;
                chk("digit_sel", digit_sel, cur.sel);
                chk("digit_sel_n", digit_sel_n, exp_n);
                chk("bcd_code", bcd_code, cur.code);
                chk("bcd_code_n", bcd_code_n, cur.code);
                chk("dec_en", dec_en, cur.en);
                chk("dec_en_n", dec_en_n, cur.en);
            end else begin
                if (in_slot) begin
                    chk("slot_len", slot_len, cur.len);
                    in_slot = 1'b0;
                    gap_cnt = 0;
                end
                gap_cnt++;
                chk("idle_dec_en", dec_en, 0);
                chk("idle_frame_tick", frame_tick, 0);
                chk("idle_sel_n", digit_sel_n, {N{1'b1}});
            end
            if (rst_n && inv_ok) begin
                chk("dec_inv", dec_inv, inv_prev);
                chk("dec_inv_n", dec_inv_n, inv_prev);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int              p, k;
        logic [4*N-1:0]  v;
        rst_n    = 1'b0;
        ena      = 1'b0;
        value    = '0;
        prescale = '0;
        lz_en    = 1'b0;
        step(3);
        chk("rst_bcd_code", bcd_code, 0);
        chk("rst_dec_en", dec_en, 0);
        chk("rst_dec_inv", dec_inv, 0);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_digit_sel", digit_sel, 0);
        chk("rst_digit_sel_n", digit_sel_n, {N{1'b1}});
        rst_n = 1'b1;
        step(2);

        enable();
        run_frame(16'h1234, 1'b0, 3, 5, 16'h1234);
        run_frame(16'h0050, 1'b1, 3, 3, 16'h0050);
        run_frame(16'h0000, 1'b1, 2, 4, 16'h0000);
        run_frame(16'h0000, 1'b0, 1, 2, 16'h0000);
        run_frame(16'h12A4, 1'b0, 3, 9, 16'h12A4);
        run_frame(16'h1234, 1'b0, 3, 7, 16'h9999);
        run_frame(16'h9999, 1'b0, 3, 1, 16'h9999);
        run_frame(16'h4321, 1'b0, 0, 6, 16'h4321);

        // Drop ena one cycle into digit 0's drive slot.
        value    = 16'h8765;
        lz_en    = 1'b0;
        prescale = PW'(2);
        push_frame(16'h8765, 1'b0, 2, 1, 1);
        step(1);
        ena = 1'b0;
        step(4);

        enable();
        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom) >> $urandom_range(0, 16);
            p = $urandom_range(0, 4);
            k = $urandom_range(0, N * (p + 1 + B) - 2);
            run_frame(v, 1'($urandom_range(0, 1)), p, k, 16'($urandom));
        end

        // Asynchronous reset two cycles into digit 0's drive slot.
        value    = 16'h5678;
        lz_en    = 1'b0;
        prescale = PW'(3);
        push_frame(16'h5678, 1'b0, 3, 1, 2);
        step(3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_digit_sel", digit_sel, 0);
        chk("async_rst_digit_sel_n", digit_sel_n, {N{1'b1}});
        chk("async_rst_dec_en", dec_en, 0);
        chk("async_rst_bcd_code", bcd_code, 0);
        chk("async_rst_frame_tick", frame_tick, 0);
        chk("async_rst_dec_inv", dec_inv, 0);
        ena = 1'b0;
        step(4);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one BCD-to-7-segment decoder across NUM_DIGITS physical digits. It snapshots a packed BCD value once per frame and selects one digit per slot. For each slot it drives the decoder inputs (code, enable, invert) and a one-hot digit-select bus. Dead-time blanking between slots prevents ghosting, and optional leading-zero suppression blanks unused high digits. Sits between the timer/counter core (value source) and the decoder/pad outputs.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; 2..8.
PRESCALE_W, 16, width of the per-slot drive-length reload value.
BLANK_CYC, 2, dead-time cycles between slots; min 1.
SEL_ACTIVE_HIGH, 1, 1 = digit_sel active-high, 0 = active-low.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
ena  in  1  scan enable; low forces IDLE.
value  in  4*NUM_DIGITS  packed BCD; nibble i = digit i, nibble 0 least significant.
prescale  in  PRESCALE_W  drive length per slot = prescale+1 cycles.
lz_en  in  1  leading-zero suppression enable.
inv  in  1  segment polarity request, forwarded to decoder.
bcd_code  out  4  decoder code; bit3 = decoder input a (MSB), bit0 = input d (LSB).
dec_en  out  1  decoder enable.
dec_inv  out  1  decoder invert.
digit_sel  out  NUM_DIGITS  one-hot digit select, polarity per SEL_ACTIVE_HIGH.
frame_tick  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Registered outputs: all outputs are registered.
- Reset values:
  - state = IDLE, idx = NUM_DIGITS-1, counters = 0, snapshot = 0.
  - bcd_code = 0, dec_en = 0, dec_inv = 0, frame_tick = 0.
  - digit_sel all inactive.
  - Assertion of rst_n mid-slot takes effect immediately.
- States:
  - IDLE: outputs inactive, idx held at NUM_DIGITS-1.
  - BLANK: digit_sel all inactive, dec_en = 0, counts BLANK_CYC cycles.
  - DRIVE: selected digit active, counts prescale+1 cycles.
- Transitions:
  - IDLE -> BLANK when ena = 1.
  - BLANK -> DRIVE after BLANK_CYC cycles. On this transition idx advances, wrapping NUM_DIGITS-1 -> 0, and the drive counter loads prescale.
  - DRIVE -> BLANK when the drive counter = 0.
  - Any state -> IDLE on the cycle after ena = 0. digit_sel and dec_en go inactive that cycle, so no partial slot continues.
- Frame start: on entry to DRIVE with idx = 0:
  - snapshot <= value.
  - frame_tick = 1 for exactly that cycle.
  - value changes mid-frame are invisible until the next frame (no tearing).
- prescale is sampled only at the DRIVE load. prescale = 0 gives a 1-cycle DRIVE. Slot period = prescale+1+BLANK_CYC; frame period = NUM_DIGITS times the slot period.
- In DRIVE:
  - bcd_code = snapshot nibble idx.
  - digit_sel bit idx active, all others inactive.
  - dec_inv = inv, registered every cycle in all states.
- Digit blanking in DRIVE: dec_en = 0 when either of the following holds, otherwise dec_en = 1. digit_sel stays active for a blanked digit, so scan timing is unchanged.
  - The nibble is greater than 9 (invalid BCD).
  - lz_en = 1, the nibble = 0, and every more-significant nibble = 0. Digit 0 is never suppressed by leading-zero logic.
- The suppression mask is computed combinationally from snapshot and registered with the slot outputs.

Decomposition:
- Shared package display_pkg:
  - state enum {IDLE, BLANK, DRIVE}.
  - BCD_MAX = 4'd9.
  - Parameter legality checks: NUM_DIGITS range, BLANK_CYC >= 1.
- One sub-module, scan_timer: a down-counter with load for both the drive and blank phases. It outputs a terminal-count pulse to the FSM.

Test Plan:
- Basic scan. Setup: NUM_DIGITS=4, BLANK_CYC=2, prescale=3, value=16'h1234, lz_en=0. Required response:
  - Slot order codes 4,3,2,1 with digit_sel 0001,0010,0100,1000.
  - Each code held 4 cycles, 2 blank cycles between slots.
  - frame_tick every 24 cycles.
- Leading-zero suppression. value=16'h0050, lz_en=1 -> dec_en = 0 for digits 3 and 2; 1 for digit 1 (code 5) and digit 0 (code 0). value=16'h0000 -> only digit 0 enabled. lz_en=0 -> all enabled.
- Invalid BCD. value=16'h12A4 -> digit 1 has dec_en = 0 and code 4'hA, other digits enabled; scan timing unchanged.
- Snapshot. Change value from 16'h1234 to 16'h9999 while digit 1 is in DRIVE -> digits 2 and 3 still show 2 and 3; 9s appear starting at the next frame_tick.
- ena and reset. ena=0 during DRIVE -> next cycle digit_sel inactive, dec_en=0; re-enable -> 2 blank cycles then digit 0 with frame_tick. rst_n low mid-DRIVE -> outputs at reset values immediately, without waiting for a clk edge.
- Polarity and edges. SEL_ACTIVE_HIGH=0 -> active select bit low, idle select = all ones. inv toggle -> dec_inv follows one cycle later. prescale=0 -> 1-cycle drive slots.
